// File: rtl/unidade_controle_vidas.sv
// Memory-game control unit with lives, timers and a selectable game length.
// It drives the address and limit counters and tells the datapath when to
// show a sequence item, clear the play register and load it.
module unidade_controle_vidas #(
  parameter int ADDR_W   = 4,
  parameter int SHOW_ON  = 1000,
  parameter int SHOW_OFF = 500,
  parameter int TIMEOUT  = 5000,
  parameter int LIVES    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              botoesIgualMemoria,
  input  logic [1:0]        modo,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] limite,
  output logic [1:0]        seletor,
  output logic              zeraR,
  output logic              registraR,
  output logic [3:0]        vidas,
  output logic              acertou,
  output logic              errou,
  output logic              timeout_fim,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TMAX0 = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
  localparam int TMAX  = (TMAX0 > TIMEOUT) ? TMAX0 : TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESPERA     = 4'h3,
    REGISTRA   = 4'h4,
    COMPARA    = 4'h5,
    PERDE      = 4'h6,
    FIM_RODADA = 4'h7,
    MOSTRA     = 4'h9,
    INTERVALO  = 4'hA,
    TIMEOUT_F  = 4'hD,
    ACERTOU    = 4'hE,
    ERROU      = 4'hF
  } estado_t;

  estado_t           estado, proximo;
  logic [TW-1:0]     timer;
  logic [1:0]        modo_reg;
  logic              causa_timeout;
  logic [ADDR_W-1:0] ultimo;
  logic              fim_on, fim_off, fim_to;

  assign fim_on  = (timer == TW'(SHOW_ON - 1));
  assign fim_off = (timer == TW'(SHOW_OFF - 1));
  assign fim_to  = (timer == TW'(TIMEOUT - 1));

  // Last round index for the latched game length (quarter, half or full memory).
  always_comb begin
    ultimo = {ADDR_W{1'b1}};
    case (modo_reg)
      2'b00:   ultimo = {ADDR_W{1'b1}} >> 2;
      2'b01:   ultimo = {ADDR_W{1'b1}} >> 1;
      default: ultimo = {ADDR_W{1'b1}};
    endcase
  end

  // Next-state logic and Moore-decoded outputs.
  always_comb begin
    proximo     = estado;
    seletor     = 2'b00;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout_fim = 1'b0;
    pronto      = 1'b0;
    db_estado   = estado;
    case (estado)
      INICIAL: begin
        zeraR   = 1'b1;
        seletor = 2'b10;
        if (iniciar) proximo = PREPARA;
      end
      PREPARA: begin
        zeraR   = 1'b1;
        proximo = MOSTRA;
      end
      MOSTRA: begin
        seletor = 2'b01;
        if (fim_on) proximo = INTERVALO;
      end
      INTERVALO: begin
        if (fim_off) proximo = (endereco == limite) ? ESPERA : MOSTRA;
      end
      ESPERA: begin
        seletor = 2'b10;
        // A press on the expiry cycle still counts as a play.
        if (jogada)      proximo = REGISTRA;
        else if (fim_to) proximo = PERDE;
      end
      REGISTRA: begin
        registraR = 1'b1;
        proximo   = COMPARA;
      end
      COMPARA: begin
        if (!botoesIgualMemoria)  proximo = PERDE;
        else if (endereco < limite) proximo = ESPERA;
        else                      proximo = FIM_RODADA;
      end
      FIM_RODADA: begin
        if (limite == ultimo) proximo = ACERTOU;
        else begin
          zeraR   = 1'b1;
          proximo = MOSTRA;
        end
      end
      PERDE: begin
        if (vidas <= 4'd1) proximo = causa_timeout ? TIMEOUT_F : ERROU;
        else begin
          zeraR   = 1'b1;
          proximo = MOSTRA;
        end
      end
      TIMEOUT_F: begin
        pronto      = 1'b1;
        timeout_fim = 1'b1;
        if (iniciar) proximo = PREPARA;
      end
      ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) proximo = PREPARA;
      end
      ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) proximo = PREPARA;
      end
      default: begin
        db_estado = 4'h9;
        proximo   = INICIAL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Shared timer, address/limit counters, lives and loss cause.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer         <= '0;
      endereco      <= '0;
      limite        <= '0;
      vidas         <= 4'd0;
      modo_reg      <= 2'b00;
      causa_timeout <= 1'b0;
    end else begin
      if (proximo != estado) timer <= '0;
      else if (estado == MOSTRA || estado == INTERVALO || estado == ESPERA)
        timer <= timer + TW'(1);
      case (estado)
        PREPARA: begin
          modo_reg <= modo;
          vidas    <= 4'(LIVES);
          endereco <= '0;
          limite   <= '0;
        end
        INTERVALO: begin
          if (fim_off)
            endereco <= (endereco == limite) ? '0 : endereco + ADDR_W'(1);
        end
        ESPERA: begin
          if (!jogada && fim_to) causa_timeout <= 1'b1;
        end
        COMPARA: begin
          if (!botoesIgualMemoria)    causa_timeout <= 1'b0;
          else if (endereco < limite) endereco <= endereco + ADDR_W'(1);
        end
        FIM_RODADA: begin
          if (limite != ultimo && limite != {ADDR_W{1'b1}}) begin
            limite   <= limite + ADDR_W'(1);
            endereco <= '0;
          end
        end
        PERDE: begin
          if (vidas != 4'd0) vidas <= vidas - 4'd1;
          if (vidas > 4'd1)  endereco <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_vidas.sv
// Scenario bench for the memory-game control unit with lives.
module tb_unidade_controle_vidas;
  localparam int ADDR_W = 4, SHOW_ON = 2, SHOW_OFF = 2, TIMEOUT = 8, LIVES = 2;

  logic              clock = 1'b0, reset = 1'b1, iniciar = 1'b0, jogada = 1'b0;
  logic              botoesIgualMemoria = 1'b1;
  logic [1:0]        modo = 2'b00;
  logic [ADDR_W-1:0] endereco, limite;
  logic [1:0]        seletor;
  logic              zeraR, registraR, acertou, errou, timeout_fim, pronto;
  logic [3:0]        vidas, db_estado;

  unidade_controle_vidas #(.ADDR_W(ADDR_W), .SHOW_ON(SHOW_ON), .SHOW_OFF(SHOW_OFF),
                           .TIMEOUT(TIMEOUT), .LIVES(LIVES)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .botoesIgualMemoria(botoesIgualMemoria), .modo(modo),
    .endereco(endereco), .limite(limite), .seletor(seletor), .zeraR(zeraR),
    .registraR(registraR), .vidas(vidas), .acertou(acertou), .errou(errou),
    .timeout_fim(timeout_fim), .pronto(pronto), .db_estado(db_estado));

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  typedef struct packed {
    logic [3:0] db; logic [3:0] limite; logic [3:0] vidas;
    logic acertou; logic errou; logic timeout_fim; logic pronto;
  } res_t;
  typedef struct packed { logic [3:0] db; logic [1:0] seletor; } step_t;

  res_t        res_q[$];
  step_t       step_q[$];
  logic [23:0] snap_q[$];

  localparam logic [23:0] RESET_SNAP = {4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 1'b1, 1'b0, 4'b0000};

  function automatic res_t result();
    return {db_estado, limite, vidas, acertou, errou, timeout_fim, pronto};
  endfunction

  function automatic logic [23:0] snap();
    return {db_estado, endereco, limite, vidas, seletor, zeraR, registraR,
            pronto, acertou, errou, timeout_fim};
  endfunction

  task automatic do_reset();
    iniciar = 0; jogada = 0; botoesIgualMemoria = 1; reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic start();
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
  endtask

  task automatic wait_db(input logic [3:0] code, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (db_estado === code) begin ok = 1; break; end
    end
  endtask

  task automatic wait_pronto(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (pronto === 1'b1) begin ok = 1; break; end
      @(negedge clock);
    end
  endtask

  task automatic play(input logic igual, output bit ok);
    wait_db(4'h3, 200, ok);
    if (!ok) return;
    botoesIgualMemoria = igual;
    jogada = 1;
    @(negedge clock) jogada = 0;
  endtask

  task automatic run_rounds(input int from, input int upto, output bit ok);
    ok = 1;
    for (int r = from; r < upto && ok; r++)
      for (int i = 0; i <= r && ok; i++) play(1'b1, ok);
  endtask

  task automatic test_reset();
    logic [23:0] e;
    reset = 1;
    snap_q.push_back(RESET_SNAP);
    @(negedge clock);
    e = snap_q.pop_front(); tests++;
    if (snap() !== e) begin fails++; $display("FAIL reset_state got %h want %h", snap(), e); end
    reset = 0;
    @(negedge clock);
    snap_q.push_back(RESET_SNAP);
    e = snap_q.pop_front(); tests++;
    if (snap() !== e) begin fails++; $display("FAIL idle_after_reset got %h want %h", snap(), e); end
  endtask

  task automatic test_win_modo00();
    bit ok; res_t e;
    do_reset(); modo = 2'b00;
    res_q.push_back({4'hE, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1});
    start();
    run_rounds(0, 4, ok);
    if (ok) wait_pronto(100, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL win_modo00_progress got stall want pronto"); end
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL win_modo00 got %h want %h", result(), e); end
  endtask

  task automatic test_show_timing();
    step_t e;
    do_reset();
    step_q.push_back({4'h1, 2'b00});
    step_q.push_back({4'h9, 2'b01}); step_q.push_back({4'h9, 2'b01});
    step_q.push_back({4'hA, 2'b00}); step_q.push_back({4'hA, 2'b00});
    step_q.push_back({4'h3, 2'b10});
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      e = step_q.pop_front(); tests++;
      if ({db_estado, seletor} !== e) begin
        fails++; $display("FAIL show_step%0d got %h want %h", i, {db_estado, seletor}, e);
      end
    end
    tests++;
    if (endereco !== 4'd0) begin fails++; $display("FAIL show_espera_addr got %0d want 0", endereco); end
  endtask

  task automatic test_wrong_play();
    bit ok; res_t e;
    do_reset(); modo = 2'b00;
    start();
    run_rounds(0, 2, ok);
    if (ok) play(1'b0, ok);
    if (ok) wait_db(4'h3, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL wrong_replay_progress got stall want espera"); end
    res_q.push_back({4'h3, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL wrong_replay got %h want %h", result(), e); end
    tests++;
    if (endereco !== 4'd0) begin fails++; $display("FAIL wrong_replay_addr got %0d want 0", endereco); end
    res_q.push_back({4'hF, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    play(1'b0, ok);
    if (ok) wait_pronto(50, ok);
    botoesIgualMemoria = 1;
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL wrong_errou got %h want %h", result(), e); end
  endtask

  task automatic test_timeout();
    bit ok; int cnt; res_t e;
    do_reset(); modo = 2'b00;
    start();
    wait_db(4'h3, 100, ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clock);
      if (db_estado === 4'h3) cnt++; else break;
    end
    tests++;
    if (cnt !== 8 || db_estado !== 4'h6) begin
      fails++; $display("FAIL timeout_window got %0d cycles state %h want 8 state 6", cnt, db_estado);
    end
    res_q.push_back({4'hD, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    wait_db(4'h3, 100, ok);
    if (ok) wait_pronto(50, ok);
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL timeout_final got %h want %h", result(), e); end
    do_reset();
    start();
    wait_db(4'h3, 100, ok);
    repeat (7) @(negedge clock);
    tests++;
    if (db_estado !== 4'h3) begin fails++; $display("FAIL timeout_edge_pre got %h want 3", db_estado); end
    botoesIgualMemoria = 1; jogada = 1;
    @(negedge clock) jogada = 0;
    tests++;
    if ({db_estado, vidas} !== {4'h4, 4'd2}) begin
      fails++; $display("FAIL timeout_edge_play got %h want 42", {db_estado, vidas});
    end
  endtask

  task automatic test_modo_long();
    bit ok; res_t e;
    do_reset(); modo = 2'b10;
    res_q.push_back({4'hE, 4'd15, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1});
    start();
    run_rounds(0, 2, ok);
    modo = 2'b00;
    if (ok) run_rounds(2, 16, ok);
    if (ok) wait_pronto(100, ok);
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL modo_long got %h want %h", result(), e); end
    modo = 2'b00;
  endtask

  task automatic test_async_reset();
    bit ok; res_t e;
    do_reset(); modo = 2'b00;
    start();
    wait_db(4'h9, 50, ok);
    snap_q.push_back(RESET_SNAP);
    #2 reset = 1;
    #1;
    tests++;
    if (snap() !== snap_q[0]) begin fails++; $display("FAIL async_reset got %h want %h", snap(), snap_q[0]); end
    void'(snap_q.pop_front());
    @(negedge clock) reset = 0;
    start();
    play(1'b0, ok);
    if (ok) play(1'b0, ok);
    if (ok) wait_pronto(50, ok);
    botoesIgualMemoria = 1;
    tests++;
    if ({db_estado, errou} !== {4'hF, 1'b1}) begin
      fails++; $display("FAIL restart_pre_errou got %h want 1f", {db_estado, errou});
    end
    res_q.push_back({4'h9, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    start();
    wait_db(4'h9, 20, ok);
    e = res_q.pop_front(); tests++;
    if (result() !== e) begin fails++; $display("FAIL restart_from_errou got %h want %h", result(), e); end
  endtask

  initial begin
    test_reset();
    test_win_modo00();
    test_show_timing();
    test_wrong_play();
    test_timeout();
    test_modo_long();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
